controller_sysid_checker: RTL

Boot-time sequencer for the system ID slave. It reads ID word (address 0) and timestamp word (address 1), compares both against the expected build values, and retries on mismatch. It reports pass/fail and the captured values to the CPU-side status logic and the reset/boot controller. It is the only master of the sysid control_slave.

---
 rtl/controller_sysid_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/controller_sysid_checker.sv
// rtl/controller_sysid_checker.sv - boot-time sysid sequencer: reads ID and timestamp words,
// compares them with the expected build values and retries on mismatch.
module controller_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd49153,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1533518009,
   parameter int          READ_LATENCY       = 0,
   parameter int          MAX_RETRIES        = 3,
   parameter int          RETRY_GAP          = 16,
   parameter int          AUTO_START         = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        id_fail,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic [3:0]  attempt_count
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      COMPARE,
      RETRY_WAIT,
      DONE
   } state_t;

   localparam logic [3:0] LAT_LAST  = 4'(READ_LATENCY);
   localparam logic [4:0] ATT_LIMIT = 5'(MAX_RETRIES);
   localparam logic [7:0] GAP_LAST  = 8'(RETRY_GAP - 1);

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [7:0]  gap_cnt;
   logic [4:0]  attempts;
   logic        auto_pending;
   logic        launch;
   logic [4:0]  next_attempts;
   logic        words_match;

   // Five-bit internal count so MAX_RETRIES=15 can reach 16 attempts; the port saturates at 15.
   assign next_attempts = attempts + 5'd1;
   assign words_match   = (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
   assign launch        = ((state == IDLE) && (start || auto_pending)) ||
                          ((state == DONE) && start);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         lat_cnt         <= 4'd0;
         gap_cnt         <= 8'd0;
         attempts        <= 5'd0;
         auto_pending    <= (AUTO_START != 0);
         sysid_address   <= 1'b0;
         sysid_read      <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         id_ok           <= 1'b0;
         id_fail         <= 1'b0;
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
         attempt_count   <= 4'd0;
      end else begin
         done <= 1'b0;
         if (launch) begin
            state         <= RD_ID;
            auto_pending  <= 1'b0;
            lat_cnt       <= 4'd0;
            attempts      <= 5'd1;
            attempt_count <= 4'd1;
            id_ok         <= 1'b0;
            id_fail       <= 1'b0;
            busy          <= 1'b1;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b0;
         end else begin
            case (state)
               RD_ID: begin
                  if (lat_cnt == LAT_LAST) begin
                     id_value      <= sysid_readdata;
                     state         <= RD_TS;
                     lat_cnt       <= 4'd0;
                     sysid_address <= 1'b1;
                  end else begin
                     lat_cnt <= lat_cnt + 4'd1;
                  end
               end
               RD_TS: begin
                  if (lat_cnt == LAT_LAST) begin
                     timestamp_value <= sysid_readdata;
                     state           <= COMPARE;
                     lat_cnt         <= 4'd0;
                     sysid_read      <= 1'b0;
                     sysid_address   <= 1'b0;
                  end else begin
                     lat_cnt <= lat_cnt + 4'd1;
                  end
               end
               COMPARE: begin
                  if (words_match) begin
                     state <= DONE;
                     id_ok <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else if (attempts <= ATT_LIMIT) begin
                     state   <= RETRY_WAIT;
                     gap_cnt <= 8'd0;
                  end else begin
                     state   <= DONE;
                     id_fail <= 1'b1;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end
               end
               RETRY_WAIT: begin
                  if (gap_cnt == GAP_LAST) begin
                     state         <= RD_ID;
                     lat_cnt       <= 4'd0;
                     sysid_read    <= 1'b1;
                     sysid_address <= 1'b0;
                     attempts      <= next_attempts;
                     attempt_count <= next_attempts[4] ? 4'hF : next_attempts[3:0];
                  end else begin
                     gap_cnt <= gap_cnt + 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
